// File: rtl/sfx_arbiter.sv
// sfx_arbiter
//   Shares the single 12-bit speaker sample path between NUM_REQ sound-effect
//   requesters. Requests are granted one at a time by fixed priority (index 0
//   highest), optionally preempting a lower-priority tone. Each granted tone is
//   a square wave paced by sample_tick, followed by a silent gap.
//
// Ports
//   clock            in   system clock
//   reset_n          in   asynchronous active-low reset
//   sample_tick      in   one-clock sample strobe, synchronous to clock
//   req              in   level requests, held until the matching grant pulse
//   req_half_period  in   8-bit half-period per requester, in samples
//   req_len          in   16-bit tone length per requester, in samples
//   mute             in   forces audio_out to 0, sequencing continues
//   grant            out  one-hot, one-clock acknowledge pulse
//   busy             out  high whenever the sequencer is not idle
//   active_id        out  index of the tone owning the speaker
//   audio_out        out  registered speaker sample
module sfx_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter logic [11:0] AMPLITUDE   = 12'd2048,
    parameter int unsigned GAP_SAMPLES = 200,
    parameter bit          PREEMPT     = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    sample_tick,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [8*NUM_REQ-1:0]    req_half_period,
    input  logic [16*NUM_REQ-1:0]   req_len,
    input  logic                    mute,
    output logic [NUM_REQ-1:0]      grant,
    output logic                    busy,
    output logic [1:0]              active_id,
    output logic [11:0]             audio_out
);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_e;

    // A zero gap length still produces one silent sample.
    localparam logic [15:0] GAP_LOAD = (GAP_SAMPLES == 0) ? 16'd1 : 16'(GAP_SAMPLES);

    state_e               state_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic                 busy_q;
    logic [1:0]           active_id_q;
    logic [11:0]          audio_q;
    logic [7:0]           period_q;
    logic [15:0]          len_cnt_q;
    logic [7:0]           phase_cnt_q;
    logic                 level_q;
    logic [15:0]          gap_cnt_q;
    // Unmuted value of the current sample; lets mute release restore the
    // tone on the next edge without waiting for a sample tick.
    logic                 raw_hi_q;

    logic                 win_valid;
    logic [1:0]           win_idx;
    logic [7:0]           win_period;
    logic [15:0]          win_len;
    logic [NUM_REQ-1:0]   grant_d;
    logic                 take_grant;
    logic                 phase_wrap;
    logic [7:0]           phase_d;
    logic                 level_d;
    logic                 sample_hi_d;

    // Lowest set request index wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int unsigned i = NUM_REQ; i > 0; i--) begin
            if (req[i-1]) begin
                win_valid = 1'b1;
                win_idx   = 2'(i - 1);
            end
        end
        win_period       = req_half_period[8*win_idx +: 8];
        win_len          = req_len[16*win_idx +: 16];
        grant_d          = '0;
        grant_d[win_idx] = 1'b1;
    end

    // Grant from IDLE, or preempt a strictly lower-priority tone in PLAY.
    // Preemption wins over a coincident sample_tick, which is dropped.
    always_comb begin
        take_grant = win_valid &&
                     ((state_q == IDLE) ||
                      (PREEMPT && (state_q == PLAY) && (win_idx < active_id_q)));
    end

    always_comb begin
        phase_wrap  = (phase_cnt_q == (period_q - 8'd1));
        phase_d     = phase_wrap ? '0 : phase_cnt_q + 8'd1;
        level_d     = phase_wrap ? ~level_q : level_q;
        sample_hi_d = level_d && (period_q != 8'd0);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            busy_q      <= 1'b0;
            active_id_q <= '0;
            audio_q     <= '0;
            period_q    <= '0;
            len_cnt_q   <= '0;
            phase_cnt_q <= '0;
            level_q     <= 1'b0;
            gap_cnt_q   <= '0;
            raw_hi_q    <= 1'b0;
        end else begin
            grant_q <= '0;
            if (take_grant) begin
                state_q     <= PLAY;
                busy_q      <= 1'b1;
                grant_q     <= grant_d;
                active_id_q <= win_idx;
                period_q    <= win_period;
                len_cnt_q   <= win_len;
                phase_cnt_q <= '0;
                level_q     <= 1'b1;
                raw_hi_q    <= 1'b1;
                audio_q     <= mute ? '0 : AMPLITUDE;
            end else begin
                case (state_q)
                    IDLE: begin
                        audio_q <= '0;
                    end
                    PLAY: begin
                        if (sample_tick) begin
                            if (len_cnt_q <= 16'd1) begin
                                state_q   <= GAP;
                                gap_cnt_q <= GAP_LOAD;
                                raw_hi_q  <= 1'b0;
                                audio_q   <= '0;
                            end else begin
                                len_cnt_q   <= len_cnt_q - 16'd1;
                                phase_cnt_q <= phase_d;
                                level_q     <= level_d;
                                raw_hi_q    <= sample_hi_d;
                                audio_q     <= (sample_hi_d && !mute) ? AMPLITUDE : '0;
                            end
                        end else begin
                            audio_q <= (raw_hi_q && !mute) ? AMPLITUDE : '0;
                        end
                    end
                    GAP: begin
                        audio_q <= '0;
                        if (sample_tick) begin
                            if (gap_cnt_q <= 16'd1) begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                gap_cnt_q <= gap_cnt_q - 16'd1;
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        audio_q <= '0;
                    end
                endcase
            end
        end
    end

    assign grant     = grant_q;
    assign busy      = busy_q;
    assign active_id = active_id_q;
    assign audio_out = audio_q;

endmodule

// File: tb/tb_sfx_arbiter.sv
// tb_sfx_arbiter
//   Self-checking bench for sfx_arbiter. Two instances share clock, tick and
//   tone tables: one with preemption enabled, one without. Expected grants are
//   queued when requests are raised and compared when grant pulses appear.
module tb_sfx_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        sample_tick;
    logic        mute;
    logic [3:0]  req;
    logic [3:0]  req_np;
    logic [31:0] hp;
    logic [63:0] len;

    logic [3:0]  grant,     grant_np;
    logic        busy,      busy_np;
    logic [1:0]  active_id, active_np;
    logic [11:0] audio,     audio_np;

    always #5 clock = ~clock;

    sfx_arbiter #(.NUM_REQ(4), .AMPLITUDE(12'd2048), .GAP_SAMPLES(200), .PREEMPT(1'b1)) dut (
        .clock(clock), .reset_n(reset_n), .sample_tick(sample_tick), .req(req),
        .req_half_period(hp), .req_len(len), .mute(mute), .grant(grant),
        .busy(busy), .active_id(active_id), .audio_out(audio)
    );

    sfx_arbiter #(.NUM_REQ(4), .AMPLITUDE(12'd2048), .GAP_SAMPLES(200), .PREEMPT(1'b0)) dut_np (
        .clock(clock), .reset_n(reset_n), .sample_tick(sample_tick), .req(req_np),
        .req_half_period(hp), .req_len(len), .mute(mute), .grant(grant_np),
        .busy(busy_np), .active_id(active_np), .audio_out(audio_np)
    );

    typedef struct {
        logic [3:0]  g;
        logic [1:0]  id;
        logic [11:0] a;
    } gexp_t;

    gexp_t       exp_q[$];
    gexp_t       exp_np_q[$];
    gexp_t       e_mon, e_mon_np;
    logic [11:0] samp_q[$];
    logic [11:0] samp;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    // Grant scoreboards; the requester drops its bit once granted.
    always @(negedge clock) begin
        if (grant != 4'b0) begin
            if (exp_q.size() == 0) begin
                check("grant_unexpected", 32'(grant), 32'd0);
            end else begin
                e_mon = exp_q.pop_front();
                check("grant_vec", 32'(grant), 32'(e_mon.g));
                check("grant_id", 32'(active_id), 32'(e_mon.id));
                check("grant_audio", 32'(audio), 32'(e_mon.a));
            end
            req = req & ~grant;
        end
    end

    always @(negedge clock) begin
        if (grant_np != 4'b0) begin
            if (exp_np_q.size() == 0) begin
                check("np_grant_unexpected", 32'(grant_np), 32'd0);
            end else begin
                e_mon_np = exp_np_q.pop_front();
                check("np_grant_vec", 32'(grant_np), 32'(e_mon_np.g));
                check("np_grant_id", 32'(active_np), 32'(e_mon_np.id));
                check("np_grant_audio", 32'(audio_np), 32'(e_mon_np.a));
            end
            req_np = req_np & ~grant_np;
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        @(negedge clock);
        #1;
    endtask

    task automatic tick();
        cyc();
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic set_tone(input int i, input logic [7:0] h, input logic [15:0] l);
        hp[8*i +: 8]   = h;
        len[16*i +: 16] = l;
    endtask

    task automatic push_grant(input logic [3:0] g, input logic [1:0] id);
        gexp_t e;
        e.g  = g;
        e.id = id;
        e.a  = 12'd2048;
        exp_q.push_back(e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        reset_n     = 1'b0;
        sample_tick = 1'b0;
        mute        = 1'b0;
        req         = '0;
        req_np      = '0;
        hp          = '0;
        len         = '0;
        repeat (3) cyc();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_active", 32'(active_id), 32'd0);
        check("rst_audio", 32'(audio), 32'd0);
        reset_n = 1'b1;
        cyc();

        // Basic tone: half-period 2, length 8, then 200-sample gap.
        set_tone(2, 8'd2, 16'd8);
        push_grant(4'b0100, 2'd2);
        req[2] = 1'b1;
        cyc();
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_first", 32'(audio), 32'd2048);
        foreach (samp_q[k]) samp_q.delete(k);
        samp_q = '{12'd2048, 12'd0, 12'd0, 12'd2048, 12'd2048, 12'd0, 12'd0, 12'd0};
        for (int k = 0; k < 8; k++) begin
            tick();
            samp = samp_q.pop_front();
            check("t1_sample", 32'(audio), 32'(samp));
        end
        check("t1_gap_busy", 32'(busy), 32'd1);
        ticks(199);
        check("t1_gap_end_m1", 32'(busy), 32'd1);
        tick();
        check("t1_idle", 32'(busy), 32'd0);

        // Two simultaneous requests: index 1 first, index 3 after tone + gap.
        set_tone(1, 8'd3, 16'd4);
        set_tone(3, 8'd1, 16'd2);
        push_grant(4'b0010, 2'd1);
        push_grant(4'b1000, 2'd3);
        req = 4'b1010;
        cyc();
        check("t2_active1", 32'(active_id), 32'd1);
        ticks(204);
        check("t2_idle_between", 32'(busy), 32'd0);
        check("t2_req3_waiting", 32'(exp_q.size()), 32'd1);
        cyc();
        settle();
        check("t2_req3_granted", 32'(exp_q.size()), 32'd0);
        check("t2_active3", 32'(active_id), 32'd3);
        ticks(202);
        check("t2_done", 32'(busy), 32'd0);

        // Preemption of requester 3 by requester 0 with a coincident tick.
        set_tone(3, 8'd5, 16'd1000);
        set_tone(0, 8'd4, 16'd3);
        push_grant(4'b1000, 2'd3);
        req[3] = 1'b1;
        cyc();
        ticks(50);
        push_grant(4'b0001, 2'd0);
        req[0]      = 1'b1;
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
        check("t3_pre_active", 32'(active_id), 32'd0);
        check("t3_pre_audio", 32'(audio), 32'd2048);
        check("t3_pre_busy", 32'(busy), 32'd1);
        ticks(2);
        check("t3_tone0_audio", 32'(audio), 32'd2048);
        tick();
        check("t3_tone0_gap", 32'(audio), 32'd0);
        ticks(199);
        check("t3_gap_busy", 32'(busy), 32'd1);
        tick();
        check("t3_no_resume", 32'(busy), 32'd0);

        // Same stimulus without preemption: requester 0 waits for tone + gap.
        begin
            gexp_t e;
            e.a  = 12'd2048;
            e.g  = 4'b1000;
            e.id = 2'd3;
            exp_np_q.push_back(e);
            e.g  = 4'b0001;
            e.id = 2'd0;
            exp_np_q.push_back(e);
        end
        req_np[3] = 1'b1;
        cyc();
        ticks(50);
        req_np[0] = 1'b1;
        ticks(1149);
        check("t4_still_busy", 32'(busy_np), 32'd1);
        check("t4_still_id3", 32'(active_np), 32'd3);
        check("t4_req0_waiting", 32'(exp_np_q.size()), 32'd1);
        tick();
        check("t4_idle", 32'(busy_np), 32'd0);
        cyc();
        settle();
        check("t4_req0_granted", 32'(exp_np_q.size()), 32'd0);
        check("t4_active0", 32'(active_np), 32'd0);
        ticks(203);
        check("t4_done", 32'(busy_np), 32'd0);

        // Length 0 plays a single sample.
        set_tone(1, 8'd3, 16'd0);
        push_grant(4'b0010, 2'd1);
        req[1] = 1'b1;
        cyc();
        tick();
        check("t5_len0_gap_audio", 32'(audio), 32'd0);
        check("t5_len0_gap_busy", 32'(busy), 32'd1);
        ticks(200);
        check("t5_len0_done", 32'(busy), 32'd0);

        // Half-period 0: silent tone of the requested length.
        set_tone(2, 8'd0, 16'd5);
        push_grant(4'b0100, 2'd2);
        req[2] = 1'b1;
        cyc();
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t5_silent_audio", 32'(audio), 32'd0);
            check("t5_silent_busy", 32'(busy), 32'd1);
        end
        ticks(200);
        check("t5_silent_done", 32'(busy), 32'd0);

        // Mute during play: output silenced next edge, counters keep running.
        set_tone(1, 8'd2, 16'd10);
        push_grant(4'b0010, 2'd1);
        req[1] = 1'b1;
        cyc();
        tick();
        check("t6_premute", 32'(audio), 32'd2048);
        mute = 1'b1;
        cyc();
        check("t6_muted", 32'(audio), 32'd0);
        ticks(3);
        check("t6_muted_tick", 32'(audio), 32'd0);
        mute = 1'b0;
        cyc();
        check("t6_unmuted", 32'(audio), 32'd2048);
        ticks(5);
        check("t6_tick9_audio", 32'(audio), 32'd2048);
        check("t6_tick9_busy", 32'(busy), 32'd1);
        tick();
        check("t6_gap_audio", 32'(audio), 32'd0);
        ticks(199);
        check("t6_gap_busy", 32'(busy), 32'd1);
        tick();
        check("t6_done", 32'(busy), 32'd0);

        // Asynchronous reset mid-tone with the request held high.
        set_tone(2, 8'd3, 16'd50);
        push_grant(4'b0100, 2'd2);
        req[2] = 1'b1;
        cyc();
        ticks(3);
        req[2] = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check("t7_rst_busy", 32'(busy), 32'd0);
        check("t7_rst_active", 32'(active_id), 32'd0);
        check("t7_rst_audio", 32'(audio), 32'd0);
        cyc();
        cyc();
        check("t7_rst_hold_grant", 32'(grant), 32'd0);
        #2;
        push_grant(4'b0100, 2'd2);
        reset_n = 1'b1;
        cyc();
        check("t7_regrant", 32'(grant), 32'd4);
        check("t7_regrant_busy", 32'(busy), 32'd1);
        ticks(250);
        check("t7_done", 32'(busy), 32'd0);

        settle();
        check("final_exp_empty", 32'(exp_q.size()), 32'd0);
        check("final_exp_np_empty", 32'(exp_np_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sfx_arbiter.md
Name: sfx_arbiter

Overview:
- Schedules and shares the single 12-bit speaker sample path, `audio_out` into `Audio_Output`, between up to NUM_REQ sound-effect requesters, such as maze move, wall hit and goal reached.
- Each requester asks for a square-wave tone: a half-period in samples and a length in samples. The block grants one at a time by fixed priority, with optional preemption.
- It generates the sample stream paced by the 20 kHz sample strobe and inserts a silent gap between tones.

Parameters:
- NUM_REQ, 4, number of requesters; index 0 has highest priority.
- AMPLITUDE, 12'd2048, sample value while the square wave is high.
- GAP_SAMPLES, 200, silent samples after each tone; 0 behaves as 1.
- PREEMPT, 1, 1 = a higher-priority request may interrupt a playing tone.

Ports:
- clock  in  1  system clock, 100 MHz.
- reset_n  in  1  asynchronous active-low reset.
- sample_tick  in  1  one-clock pulse at 20 kHz, already synchronous to `clock`.
- req  in  NUM_REQ  level request; held high until the matching grant bit pulses.
- req_half_period  in  8*NUM_REQ  slice i = half-period of requester i, in samples.
- req_len  in  16*NUM_REQ  slice i = tone length of requester i, in samples.
- mute  in  1  forces `audio_out` to 0; sequencing continues.
- grant  out  NUM_REQ  one-hot, one-clock acknowledge pulse.
- busy  out  1  high when state is not IDLE.
- active_id  out  2  index of the tone currently owning the speaker.
- audio_out  out  12  registered sample to `Audio_Output` DATA1.

Behaviour:
- Reset, asynchronous: state=IDLE, grant=0, busy=0, active_id=0, audio_out=0, all counters 0, level=0.
- All outputs are registered.
- FSM states are IDLE, PLAY and GAP.
- Grant event, which is the same in every state where a grant is allowed:
  - Taken on the clock edge where the winner is the lowest set index of `req`.
  - grant[win]=1 for exactly that one cycle; active_id=win.
  - Latch period=req_half_period[win] and len_cnt=req_len[win]; phase_cnt=0, level=1.
  - state=PLAY, audio_out=(mute?0:AMPLITUDE).
- IDLE:
  - Any req bit high -> grant event on the next edge.
  - sample_tick is ignored.
  - audio_out=0.
- PLAY, on sample_tick:
  - If len_cnt<=1: state=GAP, gap_cnt=max(GAP_SAMPLES,1), audio_out=0. req_len=0 therefore plays as length 1.
  - Else: len_cnt-=1.
    - If phase_cnt==period-1: phase_cnt=0 and level toggles.
    - Else: phase_cnt+=1.
    - audio_out=(level_next && !mute && period!=0)?AMPLITUDE:0.
  - period=0 means a silent tone of the requested length (no toggling).
- PLAY with no sample_tick: all counters and audio_out hold.
- Preemption in PLAY: if PREEMPT=1 and some req[j] is high with j<active_id, a grant event for the lowest such j happens on the next edge.
  - This takes priority over a simultaneous sample_tick; that tick is discarded.
  - No gap is inserted.
  - The preempted tone is dropped and is not resumed.
- Equal- or lower-priority requests during PLAY or GAP wait; their req stays high.
- GAP, on sample_tick:
  - If gap_cnt<=1: state=IDLE.
  - Else: gap_cnt-=1.
  - audio_out stays 0.
  - Preemption does not apply in GAP.
- mute:
  - Affects audio_out only, from the next edge.
  - Counters, grants and state are unaffected.
- A req bit dropping before its grant withdraws the request; no grant is issued.
- Sample rate is 20 kHz, so tone frequency = 20000/(2*half_period) Hz. For example, half_period=10 gives 1 kHz.
- Reset asserted mid-tone returns to the reset values immediately. No grant pulse is issued until after release.

Test Plan:
- Reset, then req=4'b0100 with half_period[2]=2 and len[2]=8:
  - Next edge: grant=4'b0100, active_id=2, busy=1, audio_out=2048.
  - Samples over the following 7 ticks: 2048,0,0,2048,2048,0,0; 8th tick -> GAP, audio_out=0.
  - After 200 more ticks: busy=0.
- req=4'b1010 raised together in IDLE:
  - grant=4'b0010 first.
  - req[3] stays high; grant=4'b1000 arrives only after requester 1's tone and the 200-tick gap complete.
- PREEMPT=1, requester 3 playing with len=1000; raise req[0] at tick 50:
  - grant=4'b0001 next edge, active_id=0, audio_out=2048.
  - No gap between the two tones; requester 3 is never resumed.
- PREEMPT=0, same stimulus:
  - Requester 3 plays all 1000 ticks and then the gap; only then grant=4'b0001.
- Edge values:
  - len=0 -> exactly one tick of tone, then GAP.
  - half_period=0 with len=5 -> audio_out=0 for 5 ticks while busy=1.
  - mute=1 during PLAY -> audio_out=0 next edge, len_cnt keeps decrementing.
- reset_n pulsed low mid-PLAY asynchronously (not on a clock edge):
  - Outputs go to reset values immediately.
  - With req held high, the first grant pulse appears on the first edge after release.
